countdown_timer_mmss: RTL and testbench
=======================================

// Module: countdown_timer_mmss
// PURPOSE
//  Microwave cook-time down counter, M:SS format: minutes digit, seconds-tens (mod 6), seconds-units (mod 10).
//  Counts down; complements the mod-6 up counter. Decrements once per 1 Hz tick strobe while running.
//  Sits between the keypad/time-entry logic (digits in) and the display decoder (digits out).
//  Raises done on reaching 0:00 so the control FSM can stop the magnetron and beep.
// PARAMETERS
//  MAX_MIN  9  largest loadable minutes digit (1..9); larger loaded values clamp to MAX_MIN
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-low (0 = reset)
//  tick       in   1  one-clk-wide 1 Hz strobe
//  load       in   1  load digits below (one-cycle pulse)
//  load_min   in   4  minutes digit to load
//  load_sect  in   4  seconds-tens digit to load
//  load_secu  in   4  seconds-units digit to load
//  start      in   1  start/resume countdown
//  stop       in   1  pause when running; cancel when paused
//  min_out    out  4  current minutes digit, BCD
//  sect_out   out  4  current seconds-tens digit, 0..5
//  secu_out   out  4  current seconds-units digit, 0..9
//  running    out  1  high in RUN
//  done       out  1  end-of-cook indication (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs registered. Reset: digits 0, state IDLE, running 0, done 0.
//  - Reset asserted mid-count takes effect immediately and aborts the count.
//  - FSM states: IDLE, RUN, PAUSED, DONE. running = (state == RUN).
//  - Each cycle, the highest-priority active command wins: reset > stop > load > start > tick.
//  - load in IDLE/PAUSED/DONE:
//      digits <= clamped inputs: min>MAX_MIN->MAX_MIN, sect>5->5, secu>9->9.
//      Next state IDLE. load in RUN is ignored.
//  - start in IDLE/PAUSED: -> RUN if time != 0:00; ignored if time == 0:00.
//      start in RUN or DONE is ignored.
//  - stop in RUN: -> PAUSED, digits held.
//  - stop in PAUSED or DONE: digits <= 0, -> IDLE.
//  - stop in IDLE: digits <= 0.
//  - tick in RUN (no higher-priority command): one decrement; new value visible the cycle after the tick.
//      secu 0 -> 9 with borrow; else secu-1.
//      On borrow: sect 0 -> 5 with borrow; else sect-1.
//      On borrow from sect: min-1.
//      Example: 1:00 -> 0:59; 0:10 -> 0:09.
//  - Tick taking the time from 0:01 to 0:00: same edge sets state DONE and asserts done.
//      Never wraps below 0:00.
//  - tick outside RUN is ignored. Digits never leave their legal ranges.
// CONFIGURATION
//  DONE_HOLD_EN defined:
//      done = (state == DONE), held until stop or load leaves DONE.
//  DONE_HOLD_EN undefined (default):
//      done is a single-cycle pulse in the first cycle of DONE.
//  Countdown logic is identical in both builds.
// TESTING
//  1. reset=0 mid-run at 1:23 -> digits 0:00, running 0, done 0 immediately (asynchronous).
//  2. load 1:00, start, one tick -> 0:59 the next cycle. One more tick -> 0:58.
//  3. load 0:02, start, two ticks -> 0:00, state DONE, done high.
//      Default build: done high exactly 1 cycle.
//      DONE_HOLD_EN build: done high until stop.
//      A further tick leaves 0:00.
//  4. load min=12, sect=7, secu=15 -> 9:59.
//      start with 0:00 loaded -> running stays 0.
//  5. running at 0:30, stop+tick in the same cycle -> PAUSED, still 0:30.
//      start -> resumes. stop, stop -> 0:00, IDLE.
//  6. in RUN, load 5:00 -> ignored.
//      In PAUSED, load+start in the same cycle -> loaded value, state IDLE, running 0.

Source files
------------

// File: rtl/countdown_timer_mmss.sv
// M:SS cook-time down counter with IDLE/RUN/PAUSED/DONE control and registered outputs.
// Define DONE_HOLD_EN to hold done for the whole DONE state instead of pulsing it once.
module countdown_timer_mmss #(
    parameter int MAX_MIN = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [3:0] load_sect,
    input  logic [3:0] load_secu,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min_out,
    output logic [3:0] sect_out,
    output logic [3:0] secu_out,
    output logic       running,
    output logic       done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] MAX_MIN_D = 4'(MAX_MIN);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [3:0] min_next;
    logic [3:0] sect_next;
    logic [3:0] secu_next;
    logic       done_next;
    logic       time_zero;
    logic       time_one;

    assign time_zero = (min_out == 4'd0) && (sect_out == 4'd0) && (secu_out == 4'd0);
    assign time_one  = (min_out == 4'd0) && (sect_out == 4'd0) && (secu_out == 4'd1);

    // Strict command priority: stop > load > start > tick; the winner may still be a no-op.
    always_comb begin
        state_next = state;
        min_next   = min_out;
        sect_next  = sect_out;
        secu_next  = secu_out;
        if (stop) begin
            if (state == RUN) begin
                state_next = PAUSED;
            end else begin
                state_next = IDLE;
                min_next   = 4'd0;
                sect_next  = 4'd0;
                secu_next  = 4'd0;
            end
        end else if (load) begin
            if (state != RUN) begin
                state_next = IDLE;
                min_next   = (load_min  > MAX_MIN_D) ? MAX_MIN_D : load_min;
                sect_next  = (load_sect > 4'd5)      ? 4'd5      : load_sect;
                secu_next  = (load_secu > 4'd9)      ? 4'd9      : load_secu;
            end
        end else if (start) begin
            if (((state == IDLE) || (state == PAUSED)) && !time_zero) begin
                state_next = RUN;
            end
        end else if (tick) begin
            if ((state == RUN) && !time_zero) begin
                if (time_one) begin
                    state_next = DONE;
                end
                if (secu_out != 4'd0) begin
                    secu_next = secu_out - 4'd1;
                end else begin
                    secu_next = 4'd9;
                    if (sect_out != 4'd0) begin
                        sect_next = sect_out - 4'd1;
                    end else begin
                        sect_next = 4'd5;
                        min_next  = min_out - 4'd1;
                    end
                end
            end
        end
    end

`ifdef DONE_HOLD_EN
    always_comb done_next = (state_next == DONE);
`else
    always_comb done_next = (state == RUN) && (state_next == DONE);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            min_out  <= 4'd0;
            sect_out <= 4'd0;
            secu_out <= 4'd0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            min_out  <= min_next;
            sect_out <= sect_next;
            secu_out <= secu_next;
            running  <= (state_next == RUN);
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Self-checking bench for countdown_timer_mmss: a seconds-based reference model feeds a scoreboard
// of expected {min, sect, secu, running, done}; honours DONE_HOLD_EN when defined.
module tb_countdown_timer_mmss;

    localparam int MAX_MIN = 9;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    typedef struct {
        logic [13:0] val;
        string       name;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       load;
    logic [3:0] load_min;
    logic [3:0] load_sect;
    logic [3:0] load_secu;
    logic       start;
    logic       stop;
    logic [3:0] min_out;
    logic [3:0] sect_out;
    logic [3:0] secu_out;
    logic       running;
    logic       done;

    exp_t        exp_q[$];
    logic [13:0] act_q[$];
    int          compared;
    int          mismatched;

    int          m_secs;
    int          m_state;
    logic        m_done;

    countdown_timer_mmss #(.MAX_MIN(MAX_MIN)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .load      (load),
        .load_min  (load_min),
        .load_sect (load_sect),
        .load_secu (load_secu),
        .start     (start),
        .stop      (stop),
        .min_out   (min_out),
        .sect_out  (sect_out),
        .secu_out  (secu_out),
        .running   (running),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] model_pack();
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] u;
        m = 4'(m_secs / 60);
        t = 4'((m_secs % 60) / 10);
        u = 4'(m_secs % 10);
        return {m, t, u, logic'(m_state == M_RUN), m_done};
    endfunction

    function automatic logic [13:0] dut_pack();
        return {min_out, sect_out, secu_out, running, done};
    endfunction

    // One clock of stimulus: advance the reference model, queue its prediction, capture the DUT.
    task automatic apply_stimulus(input logic s_stop, input logic s_load, input logic s_start,
                                  input logic s_tick, input int lm, input int lt, input int lu,
                                  input string name);
        int  prev_state;
        exp_t e;
        stop      = s_stop;
        load      = s_load;
        start     = s_start;
        tick      = s_tick;
        load_min  = 4'(lm);
        load_sect = 4'(lt);
        load_secu = 4'(lu);
        prev_state = m_state;
        if (s_stop) begin
            if (m_state == M_RUN) m_state = M_PAUSED;
            else begin
                m_state = M_IDLE;
                m_secs  = 0;
            end
        end else if (s_load) begin
            if (m_state != M_RUN) begin
                m_secs  = (lm > MAX_MIN ? MAX_MIN : lm) * 60 + (lt > 5 ? 5 : lt) * 10 + (lu > 9 ? 9 : lu);
                m_state = M_IDLE;
            end
        end else if (s_start) begin
            if ((m_state == M_IDLE || m_state == M_PAUSED) && m_secs != 0) m_state = M_RUN;
        end else if (s_tick && m_state == M_RUN) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) m_state = M_DONE;
        end
`ifdef DONE_HOLD_EN
        m_done = (m_state == M_DONE);
`else
        m_done = (prev_state == M_RUN) && (m_state == M_DONE);
`endif
        e.val  = model_pack();
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        act_q.push_back(dut_pack());
        stop  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic idle_cycle(input string name);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, name);
    endtask

    task automatic model_reset();
        m_secs  = 0;
        m_state = M_IDLE;
        m_done  = 1'b0;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [13:0] a;
        model_reset();
        e.val = model_pack(); e.name = "reset_state";
        exp_q.push_back(e); act_q.push_back(dut_pack());
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 5, "load_1_25");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "start_1_25");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_1_24");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_1_23");
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        e.val = model_pack(); e.name = "async_reset_midrun";
        exp_q.push_back(e); act_q.push_back(dut_pack());
        @(posedge clk);
        #1;
        e.name = "reset_held";
        exp_q.push_back(e); act_q.push_back(dut_pack());
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_after_reset");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); compared++;
            if (a !== e.val) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_tick();
        exp_t        e;
        logic [13:0] a;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0, "load_1_00");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "start_1_00");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_0_59");
        idle_cycle("hold_0_59");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_0_58");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "pause");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0, "load_0_10");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "start_0_10");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_0_09");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); compared++;
            if (a !== e.val) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_done();
        exp_t        e;
        logic [13:0] a;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "pause_before_done");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2, "load_0_02");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "start_0_02");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_0_01");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_0_00_done");
        idle_cycle("done_second_cycle");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_in_done");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "start_in_done");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "stop_in_done");
        idle_cycle("idle_after_done");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); compared++;
            if (a !== e.val) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_clamp();
        exp_t        e;
        logic [13:0] a;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 12, 7, 15, "load_clamp_9_59");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "start_9_59");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_9_58");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "pause_9_58");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "cancel_9_58");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 3, 4, 5, "load_3_45");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "stop_in_idle");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, "load_0_00");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "start_at_zero");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_idle_zero");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); compared++;
            if (a !== e.val) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_pause();
        exp_t        e;
        logic [13:0] a;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 0, "load_0_30");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "start_0_30");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, "stop_tick_same_cycle");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_in_paused");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "resume");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_0_29");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "stop_once");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "stop_twice");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); compared++;
            if (a !== e.val) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_load_in_run();
        exp_t        e;
        logic [13:0] a;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0, "load_2_00");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "start_2_00");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 5, 0, 0, "load_in_run");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_1_59");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "pause_1_59");
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 3, 4, 5, "load_start_paused");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "tick_after_load");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); compared++;
            if (a !== e.val) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    // Randomised single-command traffic, including loads with out-of-range digits.
    task automatic test_back_to_back();
        exp_t        e;
        logic [13:0] a;
        int          cmd;
        for (int i = 0; i < 150; i++) begin
            cmd = int'($urandom_range(0, 11));
            if (cmd <= 5)
                apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, "rand_tick");
            else if (cmd == 6 || cmd == 7)
                apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, "rand_start");
            else if (cmd == 8)
                apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, "rand_stop");
            else if (cmd == 9)
                apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, int'($urandom_range(0, 1)),
                               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand_load");
            else
                idle_cycle("rand_idle");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); compared++;
            if (a !== e.val) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h, expected %h", e.name, a, e.val);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        tick       = 1'b0;
        load       = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        load_min   = 4'd0;
        load_sect  = 4'd0;
        load_secu  = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        test_reset();
        test_tick();
        test_done();
        test_clamp();
        test_pause();
        test_load_in_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
